// File: rtl/morse_receptor.sv
// Morse receiver: recovers unit timing from the key line, deserializes one
// character (bit 0 = first unit) and strobes the pattern when the gap is seen.
module morse_receptor #(
    parameter int CICLOS_UNIDAD = 12500000,
    parameter int GAP_UNIDADES  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        linea,
    input  logic        habilitar,
    output logic [21:0] patron,
    output logic [4:0]  longitud,
    output logic        valido,
    output logic        ocupado,
    output logic        desborde
);

    localparam int CW = $clog2(CICLOS_UNIDAD);
    localparam int H  = CICLOS_UNIDAD / 2;
    // The counter runs down to zero, so loading N-1 gives a sample N cycles later.
    localparam logic [CW-1:0] CARGA_H = CW'(H - 1);
    localparam logic [CW-1:0] CARGA_U = CW'(CICLOS_UNIDAD - 1);
    localparam logic [CW-1:0] CERO    = {CW{1'b0}};
    localparam logic [2:0]    GAP     = 3'(GAP_UNIDADES);
    localparam logic [4:0]    IDX_MAX = 5'd21;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        ALINEAR  = 2'd1,
        MUESTREO = 2'd2,
        ENTREGA  = 2'd3
    } estado_t;

    estado_t       state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [4:0]    idx_r, idx_s;
    logic [2:0]    zrun_r, zrun_s;
    logic [2:0]    zrun_inc_s;
    logic [21:0]   patron_r, patron_s;
    logic [4:0]    longitud_r, longitud_s;
    logic          valido_r, valido_s;
    logic          ocupado_r, ocupado_s;
    logic          desborde_r, desborde_s;
    logic          sync1_r, s_r, s_d_r;
    logic          rise_s;

    assign rise_s     = s_r & ~s_d_r;
    assign zrun_inc_s = zrun_r + 3'd1;

    // Two-flop synchronizer on the key line plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            s_r     <= 1'b0;
            s_d_r   <= 1'b0;
        end else begin
            sync1_r <= linea;
            s_r     <= sync1_r;
            s_d_r   <= s_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= REPOSO;
            cnt_r      <= CERO;
            idx_r      <= 5'd0;
            zrun_r     <= 3'd0;
            patron_r   <= 22'd0;
            longitud_r <= 5'd0;
            valido_r   <= 1'b0;
            ocupado_r  <= 1'b0;
            desborde_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            zrun_r     <= zrun_s;
            patron_r   <= patron_s;
            longitud_r <= longitud_s;
            valido_r   <= valido_s;
            ocupado_r  <= ocupado_s;
            desborde_r <= desborde_s;
        end
    end

    // Next-state and next-output logic; valido is raised on entry to ENTREGA.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        zrun_s     = zrun_r;
        patron_s   = patron_r;
        longitud_s = longitud_r;
        valido_s   = 1'b0;
        ocupado_s  = ocupado_r;
        desborde_s = desborde_r;

        if ((state_r != REPOSO) && !habilitar) begin
            state_s   = REPOSO;
            ocupado_s = 1'b0;
        end else begin
            case (state_r)
                REPOSO: begin
                    ocupado_s = 1'b0;
                    if (habilitar && rise_s) begin
                        state_s    = ALINEAR;
                        cnt_s      = CARGA_H;
                        patron_s   = 22'd0;
                        longitud_s = 5'd0;
                        desborde_s = 1'b0;
                        ocupado_s  = 1'b1;
                    end else begin
                        state_s = REPOSO;
                    end
                end
                ALINEAR: begin
                    if (cnt_r == CERO) begin
                        if (s_r) begin
                            patron_s   = 22'd1;
                            longitud_s = 5'd1;
                            idx_s      = 5'd1;
                            zrun_s     = 3'd0;
                            cnt_s      = CARGA_U;
                            state_s    = MUESTREO;
                        end else begin
                            state_s   = REPOSO;
                            ocupado_s = 1'b0;
                        end
                    end else begin
                        cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                MUESTREO: begin
                    if (cnt_r == CERO) begin
                        cnt_s = CARGA_U;
                        if (s_r) begin
                            patron_s   = patron_r | (22'd1 << idx_r);
                            zrun_s     = 3'd0;
                            longitud_s = idx_r + 5'd1;
                        end else begin
                            zrun_s = zrun_inc_s;
                        end
                        // Gap wins over overflow when both happen on the same sample.
                        if (!s_r && (zrun_inc_s == GAP)) begin
                            state_s  = ENTREGA;
                            valido_s = 1'b1;
                        end else if (idx_r == IDX_MAX) begin
                            desborde_s = 1'b1;
                            state_s    = ENTREGA;
                            valido_s   = 1'b1;
                        end else begin
                            idx_s = idx_r + 5'd1;
                        end
                    end else begin
                        cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ENTREGA: begin
                    ocupado_s = 1'b0;
                    state_s   = REPOSO;
                end
                default: begin
                    state_s   = REPOSO;
                    ocupado_s = 1'b0;
                end
            endcase
        end
    end

    assign patron   = patron_r;
    assign longitud = longitud_r;
    assign valido   = valido_r;
    assign ocupado  = ocupado_r;
    assign desborde = desborde_r;

endmodule

// File: doc/morse_receptor.md
# morse_receptor

Morse receiver for the Morse transmitter design. It recovers unit timing from a single on/off key line, deserializes one character into a 22-bit pattern (bit index 0 = first unit sent, matching the transmitter's upward bit-select order), detects the inter-character gap, and presents the pattern with its length and a one-cycle valid strobe. It sits between the pin or loopback of the transmitter key output and any character decoder or display logic.

## Interface
- CICLOS_UNIDAD, 12500000: clock cycles per Morse unit; must be ≥4.
- GAP_UNIDADES, 3: consecutive zero units that end a character; range 2–7.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- linea  in  1  asynchronous key line; 1 = tone on. Synchronized internally.
- habilitar  in  1  receiver enable; 0 forces a return to idle.
- patron  out  22  received pattern; bit k = unit k; bits at and above longitud are 0.
- longitud  out  5  number of units up to and including the last 1 unit, in the range 1–22.
- valido  out  1  one-cycle strobe when patron and longitud become valid.
- ocupado  out  1  1 while a character is being received.
- desborde  out  1  1 with valido when 22 units were sampled without a gap.

## Operation
- Reset is one clock with an asynchronous, active-low reset. In reset, every output, the state, the counters and the synchronizer are cleared to 0.
- linea passes through a 2-flop synchronizer, producing s. Edge detection uses s and its one-cycle delay.
- Let H = CICLOS_UNIDAD/2 (floor) and U = CICLOS_UNIDAD. The timing counter is ceil(log2(U)) bits wide. The unit index idx is 5 bits. The zero-run counter is 3 bits.
- State REPOSO:
  - ocupado = 0.
  - When habilitar = 1 and s rises, go to ALINEAR, load the counter with H, clear patron, longitud and desborde, and set ocupado = 1.
- State ALINEAR:
  - Count down H cycles, then sample s.
  - If the sample is 0, treat it as a glitch: return to REPOSO with no valido and ocupado = 0.
  - If the sample is 1, write patron[0] = 1, set idx = 1 and the zero-run to 0, reload the counter with U, and go to MUESTREO.
- State MUESTREO, one sample every U cycles:
  - Sample = 1: write patron[idx] = 1, set the zero-run to 0, and set longitud = idx+1.
  - Sample = 0: leave patron[idx] = 0 and increment the zero-run.
  - If the zero-run reaches GAP_UNIDADES, go to ENTREGA.
  - Otherwise, if idx = 21, set desborde = 1 and go to ENTREGA. longitud keeps its last value, which is 22 if unit 21 was 1.
  - Otherwise, increment idx.
  - The gap check has priority over the overflow check on the same sample.
- State ENTREGA:
  - Assert valido for exactly one cycle, clear ocupado, and go to REPOSO.
  - patron, longitud and desborde hold until the next accepted start edge.
- habilitar = 0 in any non-idle state returns the block to REPOSO on the next cycle. There is no valido, ocupado goes to 0, and partial patron contents are don't-care but must not be strobed.
- A rising edge seen while in MUESTREO is ignored. Only the mid-unit samples count.
- When the sampled line is 1 at the moment ENTREGA returns to REPOSO, no start is taken until a fresh 0→1 edge occurs.

## Timing
- Let the synchronized rising edge be seen in cycle t. This is 2–3 clocks after the linea pin edge.
- Sample 0 is taken at t+H. Sample k is taken at t+H+k·U.
- The terminating sample is n, where n = longitud−1+GAP_UNIDADES, or n = 21 on overflow. valido is high in cycle t+H+n·U+1.
- The earliest new start edge is accepted in the cycle after valido.
- The minimum spacing between characters is therefore GAP_UNIDADES units of 0, which matches the transmitter's character gap.

## Test plan
- Letter A, with CICLOS_UNIDAD=8 and GAP_UNIDADES=3: drive linea units 1,0,1,1,1 then 0s. Required: valido in cycle t+4+7·8+1, patron=22'h00001D, longitud=5, desborde=0, and ocupado high from t+1 until valido.
- Letter E, a single dot: drive units 1,0,0,0. Required: patron=22'h000001, longitud=1, and valido at t+4+3·8+1.
- Overflow: hold linea=1 for 22 units. Required: desborde=1, longitud=22, patron=22'h3FFFFF, and valido at t+4+21·8+1.
- Glitch: drive a 2-cycle pulse on linea. Required: back to REPOSO after H, no valido, and ocupado drops.
- Abort and reset: drop habilitar during unit 3 of letter A. Required: no valido, ocupado=0 next cycle, and the next full letter A is decoded correctly. Then assert rst_n=0 mid-character. Required: all outputs 0 immediately and asynchronously.
- Back-to-back: send A, a gap of exactly 3 units, then E. Required: two valido strobes, with patron 22'h00001D and then 22'h000001.
